// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample widths, serializer state encoding and the
// round/shift/saturate conversion used on each filter result.
package fir_pkg;

  localparam int unsigned IN_SAMPLE_WIDTH  = 16;
  localparam int unsigned OUT_SAMPLE_WIDTH = 32;
  localparam int unsigned WIDE_WIDTH       = OUT_SAMPLE_WIDTH + 1;

  localparam logic signed [WIDE_WIDTH-1:0] SAT_MAX = WIDE_WIDTH'(32767);
  localparam logic signed [WIDE_WIDTH-1:0] SAT_MIN = WIDE_WIDTH'(-32768);

  typedef enum logic {IDLE, SHIFTING} state_t;

  typedef struct packed {
    logic [IN_SAMPLE_WIDTH-1:0] sample;
    logic                       saturated;
  } convResult_t;

  // Half-up rounding, arithmetic shift and clamp to 16 bits, done in 33 bits
  // so the rounding add on a full-scale positive result cannot wrap.
  function automatic convResult_t roundShiftSat(
    input logic [OUT_SAMPLE_WIDTH-1:0] result,
    input int unsigned                 shift
  );
    logic signed [WIDE_WIDTH-1:0] wide;
    convResult_t                  conv;
    wide = $signed({result[OUT_SAMPLE_WIDTH-1], result});
    if (shift > 0) begin
      wide = wide + $signed(WIDE_WIDTH'(1) << (shift - 1));
    end
    wide = wide >>> shift;
    conv.saturated = 1'b0;
    if (wide > SAT_MAX) begin
      conv.sample    = IN_SAMPLE_WIDTH'(16'h7FFF);
      conv.saturated = 1'b1;
    end else if (wide < SAT_MIN) begin
      conv.sample    = IN_SAMPLE_WIDTH'(16'h8000);
      conv.saturated = 1'b1;
    end else begin
      conv.sample = wide[IN_SAMPLE_WIDTH-1:0];
    end
    return conv;
  endfunction

endpackage

// File: rtl/fir_frame_fifo.sv
// Synchronous frame FIFO; a push into a full FIFO is still taken when a pop
// frees the slot on the same edge.
module fir_frame_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clkIn,
  input  logic                     nResetIn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         pushData,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             wrEn;
  logic             rdEn;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdEn    = pop && !empty;
  assign wrEn    = push && (!full || rdEn);
  assign popData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_W'(1);
      if (rdEn) rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(wrEn) - CNT_W'(rdEn);
    end
  end

  always_ff @(posedge clkIn) begin
    if (wrEn) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fir_result_serializer.sv
// Converts each finished FIR frame to 16-bit samples, buffers whole frames and
// streams them out MSB slice first over a valid/ready handshake.
module fir_result_serializer
  import fir_pkg::*;
#(
  parameter int unsigned SAMPLES_NUM = 4,
  parameter int unsigned SHIFT       = 15,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                                clkIn,
  input  logic                                nResetIn,
  input  logic                                doneIn,
  input  logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] dataIn,
  output logic                                frameReadyOut,
  output logic [IN_SAMPLE_WIDTH-1:0]          sampleOut,
  output logic                                sampleValidOut,
  input  logic                                sampleReadyIn,
  output logic                                overflowOut,
  output logic                                saturateOut
);

  localparam int unsigned FRAME_W  = IN_SAMPLE_WIDTH * SAMPLES_NUM;
  localparam int unsigned IDX_W    = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_NUM - 1);

  logic [FRAME_W-1:0]          frameData;
  logic [SAMPLES_NUM-1:0]      satVec;
  logic [FRAME_W-1:0]          popData;
  logic                        fifoFull;
  logic                        fifoEmpty;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;
  logic                        fifoPop;
  logic                        pushAccepted;

  state_t             state, stateNext;
  logic [IDX_W-1:0]   index, indexNext;
  logic [FRAME_W-1:0] shiftReg, shiftNext;
  logic               validNext;

  for (genvar k = 0; k < SAMPLES_NUM; k++) begin : gConv
    convResult_t conv;
    assign conv = roundShiftSat(dataIn[OUT_SAMPLE_WIDTH*k +: OUT_SAMPLE_WIDTH], SHIFT);
    assign frameData[IN_SAMPLE_WIDTH*k +: IN_SAMPLE_WIDTH] = conv.sample;
    assign satVec[k] = conv.saturated;
  end

  fir_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clkIn    (clkIn),
    .nResetIn (nResetIn),
    .push     (doneIn),
    .pop      (fifoPop),
    .pushData (frameData),
    .popData  (popData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign pushAccepted  = doneIn && (!fifoFull || fifoPop);
  assign frameReadyOut = (fifoCount < ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
  assign sampleOut     = shiftReg[FRAME_W-1 -: IN_SAMPLE_WIDTH];

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state          <= IDLE;
      index          <= '0;
      shiftReg       <= '0;
      sampleValidOut <= 1'b0;
    end else begin
      state          <= stateNext;
      index          <= indexNext;
      shiftReg       <= shiftNext;
      sampleValidOut <= validNext;
    end
  end

  // Next-state: load on pop, advance on handshake, reload without a bubble.
  always_comb begin
    stateNext = state;
    indexNext = index;
    shiftNext = shiftReg;
    validNext = sampleValidOut;
    fifoPop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shiftNext = popData;
          indexNext = '0;
          validNext = 1'b1;
          stateNext = SHIFTING;
        end
      end
      SHIFTING: begin
        if (sampleValidOut && sampleReadyIn) begin
          if (index == LAST_IDX) begin
            if (!fifoEmpty) begin
              fifoPop   = 1'b1;
              shiftNext = popData;
              indexNext = '0;
            end else begin
              validNext = 1'b0;
              stateNext = IDLE;
            end
          end else begin
            shiftNext = shiftReg << IN_SAMPLE_WIDTH;
            indexNext = index + IDX_W'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
        validNext = 1'b0;
      end
    endcase
  end

  // Sticky status, cleared only by reset.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      overflowOut <= 1'b0;
      saturateOut <= 1'b0;
    end else begin
      if (doneIn && !pushAccepted) overflowOut <= 1'b1;
      if (pushAccepted && (|satVec)) saturateOut <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_result_serializer.sv
// Randomized and directed bench for fir_result_serializer against a
// frame/sample queue reference model.
module tb_fir_result_serializer;

  localparam int N     = 4;
  localparam int SH    = 15;
  localparam int DEPTH = 2;

  logic            clkIn;
  logic            nResetIn;
  logic            doneIn;
  logic [32*N-1:0] dataIn;
  logic            frameReadyOut;
  logic [15:0]     sampleOut;
  logic            sampleValidOut;
  logic            sampleReadyIn;
  logic            overflowOut;
  logic            saturateOut;

  int checks;
  int errors;

  logic [15:0] fifoQ[$];
  logic [15:0] curQ[$];
  int          fifoFrames;
  bit          active;
  bit          ovfM;
  bit          satM;

  fir_result_serializer #(
    .SAMPLES_NUM (N),
    .SHIFT       (SH),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clkIn          (clkIn),
    .nResetIn       (nResetIn),
    .doneIn         (doneIn),
    .dataIn         (dataIn),
    .frameReadyOut  (frameReadyOut),
    .sampleOut      (sampleOut),
    .sampleValidOut (sampleValidOut),
    .sampleReadyIn  (sampleReadyIn),
    .overflowOut    (overflowOut),
    .saturateOut    (saturateOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain-integer reference conversion: floor((x + 2^(SH-1)) / 2^SH), clamped.
  function automatic logic [15:0] refConvert(input logic [31:0] x, output bit sat);
    longint v;
    v = longint'($signed(x));
    if (SH > 0) v = v + (longint'(1) << (SH - 1));
    v = v >>> SH;
    sat = 1'b0;
    if (v > 32767) begin
      v = 32767;
      sat = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      sat = 1'b1;
    end
    return 16'(v);
  endfunction

  task automatic modelReset();
    fifoQ.delete();
    curQ.delete();
    fifoFrames = 0;
    active = 1'b0;
    ovfM = 1'b0;
    satM = 1'b0;
  endtask

  // Effect of one clock edge given the inputs presented before it.
  task automatic modelStep(input logic done, input logic [32*N-1:0] data, input logic ready);
    bit          anySat;
    bit          s;
    logic [31:0] r;
    logic [15:0] y;
    if (active && ready) begin
      void'(curQ.pop_front());
      if (curQ.size() == 0) active = 1'b0;
    end
    if (!active && fifoFrames > 0) begin
      for (int i = 0; i < N; i++) curQ.push_back(fifoQ.pop_front());
      fifoFrames--;
      active = 1'b1;
    end
    if (done) begin
      if (fifoFrames < DEPTH) begin
        anySat = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
          r = data[32*k +: 32];
          y = refConvert(r, s);
          fifoQ.push_back(y);
          anySat |= s;
        end
        fifoFrames++;
        if (anySat) satM = 1'b1;
      end else begin
        ovfM = 1'b1;
      end
    end
  endtask

  task automatic checkOutputs();
    checkEq("valid", 32'(sampleValidOut), 32'(active));
    if (active) checkEq("sample", 32'(sampleOut), 32'(curQ[0]));
    checkEq("frameReady", 32'(frameReadyOut), 32'(fifoFrames < DEPTH));
    checkEq("overflow", 32'(overflowOut), 32'(ovfM));
    checkEq("saturate", 32'(saturateOut), 32'(satM));
  endtask

  // Called at a negedge: drive inputs, advance the model, check after the edge.
  task automatic step(input logic done, input logic [32*N-1:0] data, input logic ready);
    doneIn = done;
    dataIn = data;
    sampleReadyIn = ready;
    modelStep(done, data, ready);
    @(negedge clkIn);
    checkOutputs();
  endtask

  function automatic logic [31:0] randResult();
    int v;
    case ($urandom_range(0, 2))
      0: v = int'($urandom());
      1: v = int'($urandom_range(0, 2097152)) - 1048576;
      default: v = (int'($urandom_range(0, 4000)) - 2000) * 32768 + 16384
                   + int'($urandom_range(0, 2)) - 1;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [32*N-1:0] randFrame();
    logic [32*N-1:0] f;
    for (int k = 0; k < N; k++) f[32*k +: 32] = randResult();
    return f;
  endfunction

  logic [32*N-1:0] frm;
  int              cnt;

  initial begin
    checks = 0;
    errors = 0;
    nResetIn = 1'b0;
    doneIn = 1'b0;
    dataIn = '0;
    sampleReadyIn = 1'b0;
    modelReset();
    repeat (2) @(negedge clkIn);
    checkEq("rst sample", 32'(sampleOut), 32'h0);
    checkEq("rst valid", 32'(sampleValidOut), 32'h0);
    checkEq("rst frameReady", 32'(frameReadyOut), 32'h1);
    nResetIn = 1'b1;
    @(negedge clkIn);
    checkOutputs();

    // Rounding boundaries
    frm = {32'h0000_4000, 32'hFFFF_C000, 32'hFFFF_BFFF, 32'h0000_3FFF};
    step(1'b1, frm, 1'b1);
    checkEq("lat valid low", 32'(sampleValidOut), 32'h0);
    step(1'b0, '0, 1'b1);
    checkEq("lat valid high", 32'(sampleValidOut), 32'h1);
    checkEq("round s3", 32'(sampleOut), 32'h0001);
    step(1'b0, '0, 1'b1);
    checkEq("round s2", 32'(sampleOut), 32'h0000);
    step(1'b0, '0, 1'b1);
    checkEq("round s1", 32'(sampleOut), 32'hFFFF);
    step(1'b0, '0, 1'b1);
    checkEq("round s0", 32'(sampleOut), 32'h0000);
    step(1'b0, '0, 1'b1);
    checkEq("round idle", 32'(sampleValidOut), 32'h0);
    checkEq("round nosat", 32'(saturateOut), 32'h0);

    // Saturation
    frm = {32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0};
    step(1'b1, frm, 1'b1);
    step(1'b0, '0, 1'b1);
    checkEq("sat pos", 32'(sampleOut), 32'h7FFF);
    step(1'b0, '0, 1'b1);
    checkEq("sat neg", 32'(sampleOut), 32'h8000);
    checkEq("sat flag", 32'(saturateOut), 32'h1);
    repeat (4) step(1'b0, '0, 1'b1);

    // Overflow with the sink stalled: one frame in the shifter, two in the FIFO
    step(1'b1, randFrame(), 1'b0);
    step(1'b1, randFrame(), 1'b0);
    step(1'b1, randFrame(), 1'b0);
    checkEq("ovf frameReady", 32'(frameReadyOut), 32'h0);
    step(1'b1, randFrame(), 1'b0);
    checkEq("ovf flag", 32'(overflowOut), 32'h1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (sampleValidOut) cnt++;
      step(1'b0, '0, 1'b1);
    end
    checkEq("ovf drained", 32'(cnt), 32'd12);

    // Back-to-back frames without a bubble
    step(1'b1, randFrame(), 1'b1);
    step(1'b1, randFrame(), 1'b1);
    for (int i = 0; i < 2 * N; i++) begin
      checkEq("b2b valid", 32'(sampleValidOut), 32'h1);
      step(1'b0, '0, 1'b1);
    end
    checkEq("b2b end", 32'(sampleValidOut), 32'h0);

    // Asynchronous reset in the middle of a frame
    step(1'b1, randFrame(), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    doneIn = 1'b0;
    #2 nResetIn = 1'b0;
    #1;
    modelReset();
    checkEq("arst valid", 32'(sampleValidOut), 32'h0);
    checkEq("arst sample", 32'(sampleOut), 32'h0);
    checkEq("arst overflow", 32'(overflowOut), 32'h0);
    checkEq("arst saturate", 32'(saturateOut), 32'h0);
    checkEq("arst frameReady", 32'(frameReadyOut), 32'h1);
    @(negedge clkIn);
    nResetIn = 1'b1;
    @(negedge clkIn);
    checkOutputs();
    repeat (6) step(1'b0, '0, 1'b1);

    // Randomized traffic with backpressure
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, randFrame(), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 2) == 0, randFrame(), $urandom_range(0, 3) == 0);
    end
    repeat (40) step(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
